// File: rtl/bilstm_pkg.sv
// Shared types for the BiLSTM backward-path datapath: FSM state encoding and the
// default signed word used between the input FIFO and the LSTM cells.
package bilstm_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic signed [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/seq_buffer_ram.sv
// Sequence store: one write port fed by the FIFO capture path, one combinational
// read port for the replay path. Written as distributed RAM (async read).
module seq_buffer_ram
    import bilstm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 80,
    parameter int ADDR_W     = 7
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset: contents persist and are fully rewritten by every load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bilstm_seq_reverser.sv
// Drains one SEQ_LEN x VEC_LEN sequence from the input FIFO, then replays it to the
// backward LSTM cell with timesteps reversed and element order kept.
module bilstm_seq_reverser
    import bilstm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int VEC_LEN    = 8,
    parameter int SEQ_LEN    = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic signed [DATA_WIDTH-1:0] fifo_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last_elem,
    output logic                         out_last_step,
    output logic                         busy,
    output logic                         done
);

    localparam int TOTAL  = SEQ_LEN * VEC_LEN;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int T_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int E_W    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [T_W-1:0]   T_LAST  = T_W'(SEQ_LEN - 1);
    localparam logic [E_W-1:0]   E_LAST  = E_W'(VEC_LEN - 1);

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             issued;
    logic [CNT_W-1:0]             captured;
    logic                         rd_pending;
    logic [T_W-1:0]               t_idx;
    logic [E_W-1:0]               e_idx;
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic [ADDR_W-1:0]            rd_addr;
    logic signed [DATA_WIDTH-1:0] rd_word;
    logic                         load_word;
    logic                         last_accept;
    logic                         at_final_word;

    seq_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TOTAL),
        .ADDR_W     (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (fifo_data),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    // FIFO data lands one cycle after the strobe; capture it at the running index.
    assign wr_en   = rd_pending && (captured != TOTAL_C);
    assign wr_addr = captured[ADDR_W-1:0];
    assign rd_addr = ADDR_W'(int'(t_idx) * VEC_LEN + int'(e_idx));

    assign at_final_word = (t_idx == '0) && (e_idx == E_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fifo_rd_en  = 1'b0;
        load_word   = 1'b0;
        last_accept = 1'b0;
        busy        = (state != IDLE);
        done        = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                fifo_rd_en = !fifo_empty && (issued < TOTAL_C);
                if (captured == TOTAL_C) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                last_accept = out_valid && out_ready && out_last_step && out_last_elem;
                load_word   = !out_valid || (out_ready && !last_accept);
                if (last_accept) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued     <= '0;
            captured   <= '0;
            rd_pending <= 1'b0;
            t_idx      <= '0;
            e_idx      <= '0;
        end else begin
            rd_pending <= fifo_rd_en;
            if (state == IDLE && start) begin
                issued   <= '0;
                captured <= '0;
            end else begin
                if (fifo_rd_en) begin
                    issued <= issued + CNT_W'(1);
                end
                if (wr_en) begin
                    captured <= captured + CNT_W'(1);
                end
            end
            // Replay walks t downward, e upward; parks on the final word.
            if (state == LOAD && state_nxt == EMIT) begin
                t_idx <= T_LAST;
                e_idx <= '0;
            end else if (load_word && !at_final_word) begin
                if (e_idx == E_LAST) begin
                    e_idx <= '0;
                    t_idx <= t_idx - T_W'(1);
                end else begin
                    e_idx <= e_idx + E_W'(1);
                end
            end
        end
    end

    // ---- output register stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last_elem <= 1'b0;
            out_last_step <= 1'b0;
        end else if (load_word) begin
            out_valid     <= 1'b1;
            out_data      <= rd_word;
            out_last_elem <= (e_idx == E_LAST);
            out_last_step <= (t_idx == '0);
        end else if (last_accept) begin
            out_valid     <= 1'b0;
            out_last_elem <= 1'b0;
            out_last_step <= 1'b0;
        end
    end

endmodule
